// File: rtl/flag_branch_unit_if.sv
// Execute-stage flag / branch bus shared by the pipeline and flag_branch_unit.
// The master side is the pipeline (ALU result, branch request, stall); the
// slave side is the flag/branch unit (flag register, stall request, redirect).
interface flag_branch_unit_if #(
    parameter int PC_W = 16
);
    logic [2:0]      alu_flags;
    logic [2:0]      alu_op;
    logic            alu_valid;
    logic            stall_in;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [2:0]      flags_q;
    logic            stall_req;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            flush;

    modport master (
        output alu_flags, alu_op, alu_valid, stall_in,
        output br_valid, br_cond, br_target,
        input  flags_q, stall_req, redirect, redirect_pc, flush
    );

    modport slave (
        input  alu_flags, alu_op, alu_valid, stall_in,
        input  br_valid, br_cond, br_target,
        output flags_q, stall_req, redirect, redirect_pc, flush
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register with per-opcode write masks, conditional
// branch resolution and a one-cycle PC redirect / wrong-path flush.
// Optional macro FLAG_BYPASS_EN: on a same-cycle flag-write/branch hazard the
// branch is resolved against the merged (about-to-be-written) flags instead of
// stalling for one cycle.
module flag_branch_unit #(
    parameter int         PC_W     = 16,
    parameter logic [2:0] FLAG_RST = 3'b000
) (
    input  logic               clk,
    input  logic               rst,
    flag_branch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        REDIRECT   = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [2:0]      flags_r;
    logic [2:0]      flags_d;
    logic [2:0]      wr_mask;
    logic            flag_wr;
    logic            hazard;
    logic            capture;
    logic            stall_req_c;
    logic [2:0]      cond_q;
    logic [PC_W-1:0] tgt_q;

    // Flags {Z,V,N} written by each opcode: arithmetic writes all,
    // logic/shift writes Z only, RED and PADSUB leave the flags alone.
    function automatic logic [2:0] op_mask(input logic [2:0] op);
        logic [2:0] m;
        m = 3'b000;
        case (op)
            3'b000, 3'b001:                 m = 3'b111;
            3'b010, 3'b100, 3'b101, 3'b110: m = 3'b100;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

    // Branch condition code evaluated against a {Z,V,N} flag vector.
    function automatic logic cond_met(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n, r;
        z = f[2];
        v = f[1];
        n = f[0];
        r = 1'b1;
        case (cc)
            3'b000:  r = ~z;
            3'b001:  r = z;
            3'b010:  r = ~z & ~n;
            3'b011:  r = n;
            3'b100:  r = z | (~z & ~n);
            3'b101:  r = n | z;
            3'b110:  r = v;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Next flag value: masked merge of ALU flags over the held register.
    always_comb begin
        wr_mask = op_mask(bus.alu_op);
        flag_wr = bus.alu_valid & ~bus.stall_in;
        flags_d = flags_r;
        if (flag_wr) begin
            flags_d = (bus.alu_flags & wr_mask) | (flags_r & ~wr_mask);
        end
        hazard = bus.br_valid & flag_wr & (wr_mask != 3'b000);
    end

    // Flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= FLAG_RST;
        end else begin
            flags_r <= flags_d;
        end
    end

    // Branch FSM next-state, capture strobe and stall request.
    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        stall_req_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.br_valid && !bus.stall_in) begin
`ifdef FLAG_BYPASS_EN
                    // flags_d equals flags_r whenever there is no hazard here
                    if (cond_met(bus.br_cond, hazard ? flags_d : flags_r)) begin
                        capture = 1'b1;
                        state_d = REDIRECT;
                    end
`else
                    if (hazard && bus.br_cond != 3'b111) begin
                        stall_req_c = 1'b1;
                        capture     = 1'b1;
                        state_d     = WAIT_FLAGS;
                    end else if (cond_met(bus.br_cond, flags_r)) begin
                        capture = 1'b1;
                        state_d = REDIRECT;
                    end
`endif
                end
            end
            WAIT_FLAGS: begin
                if (!bus.stall_in) begin
                    state_d = cond_met(cond_q, flags_r) ? REDIRECT : IDLE;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and captured branch condition/target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cond_q <= '0;
            tgt_q  <= '0;
        end else begin
            state <= state_d;
            if (capture) begin
                cond_q <= bus.br_cond;
                tgt_q  <= bus.br_target;
            end
        end
    end

    assign bus.flags_q     = flags_r;
    assign bus.stall_req   = stall_req_c & ~rst;
    assign bus.redirect    = (state == REDIRECT);
    assign bus.flush       = (state == REDIRECT);
    assign bus.redirect_pc = (state == REDIRECT) ? tgt_q : '0;

endmodule
